stq_ctrl: RTL
=============

# stq_ctrl

Store-queue occupancy controller for the load/store unit. It owns the store queue's head, tail and occupancy registers, and supplies the tail and head that the dispatch-side store-index logic consumes. It allocates entries for stores dispatched each cycle, retires committed stores to the data cache over a request/acknowledge handshake, and rolls the tail back on recovery.

## Interface
Parameters:
- SIZE_LSQ, 32, number of store-queue entries; power of two.
- SIZE_LSQ_LOG, 5, log2(SIZE_LSQ).

Ports:
- clk  in  1  core clock; all state updates on the rising edge.
- reset  in  1  asynchronous, active-low reset.
- dispatchValid_i  in  1  a dispatch bundle is presented this cycle.
- cntStNew_i  in  3  number of stores in the bundle, 0..4.
- commitCnt_i  in  3  number of oldest uncommitted stores committed this cycle, 0..4.
- recover_i  in  1  flush all uncommitted stores.
- cacheWrAck_i  in  1  the data cache accepted the current store write.
- stqHead_o  out  SIZE_LSQ_LOG  index of the oldest entry.
- stqTail_o  out  SIZE_LSQ_LOG  next free entry.
- stqInsts_o  out  SIZE_LSQ_LOG+1  occupied entries, 0..SIZE_LSQ.
- stqFull_o  out  1  free entries < 4; dispatch must stall.
- dispatchAccept_o  out  1  dispatchValid_i && !stqFull_o && !recover_i (combinational).
- cacheWrReq_o  out  1  store write request to the data cache.
- cacheWrIdx_o  out  SIZE_LSQ_LOG  entry being written; equals stqHead_o.

## Operation
Internal registers:
- head, tail.
- insts (SIZE_LSQ_LOG+1 bits).
- commitPend: committed but not yet drained, SIZE_LSQ_LOG+1 bits.
- 1-bit FSM state.

Per-cycle updates:
- Let alloc = dispatchAccept_o ? cntStNew_i : 0, and ack = cacheWrReq_o && cacheWrAck_i.
- Normal cycle:
  - tail += alloc, mod SIZE_LSQ.
  - head += ack.
  - insts = insts + alloc − ack.
  - commitPend = commitPend + commitCnt_i − ack.
- commitCnt_i is clamped to (insts − commitPend); excess commits are dropped.
- Recovery, when recover_i = 1:
  - alloc is forced to 0 and commitCnt_i is still honoured in the same cycle.
  - insts_next = commitPend_next.
  - tail_next = head_next + commitPend_next, mod SIZE_LSQ.
  - Committed stores are never flushed.
- stqFull_o = (SIZE_LSQ − insts) < 4, computed from registered insts.

Drain FSM:
- IDLE: cacheWrReq_o = 0. Go to REQ when commitPend_next > 0.
- REQ: cacheWrReq_o = 1, held until cacheWrAck_i.
  - On ack, stay in REQ if commitPend_next > 0, otherwise go to IDLE.
  - Back-to-back acks retire one store per cycle.
- recover_i does not disturb the FSM or an outstanding request.

Reset: head = tail = 0, insts = 0, commitPend = 0, FSM = IDLE. Resulting outputs:
- stqHead_o = stqTail_o = 0.
- stqInsts_o = 0.
- stqFull_o = 0.
- cacheWrReq_o = 0.
- cacheWrIdx_o = 0.

## Timing
- All outputs except dispatchAccept_o are registered.
- Allocation appears on stqTail_o and stqInsts_o one cycle after acceptance.
- Commit-to-request latency:
  - From IDLE, cacheWrReq_o rises one cycle after commitCnt_i ≠ 0.
  - In REQ, the request stays high continuously.
- On the ack edge, stqHead_o and cacheWrIdx_o advance in the next cycle.
- Wrap-around: head and tail wrap modulo SIZE_LSQ. insts distinguishes empty (0) from full (SIZE_LSQ) when head == tail.
- Simultaneous dispatch, commit and ack in one cycle: all three apply additively, as in Operation.
- Reset asserted mid-request drops cacheWrReq_o asynchronously. The cache must tolerate an abandoned request.

## Test plan
- Reset, then dispatch 4 stores per cycle for 7 cycles:
  - tail = 28, insts = 28, stqFull_o = 0.
  - Dispatch once more with cntStNew_i = 1: tail = 29, insts = 29, stqFull_o = 1.
  - Further dispatchValid_i yields dispatchAccept_o = 0 and no state change.
- Insts = 3, commitCnt_i = 3, cacheWrAck_i held high:
  - cacheWrReq_o rises next cycle and stays high 3 cycles.
  - Head advances 0→1→2→3, then the FSM returns to IDLE with insts = 0.
- Wrap: head = 30, tail = 30; dispatch 4 → tail = 2, insts = 4. Commit 4 and ack all → head = 2, insts = 0.
- Recovery: insts = 6, commitPend = 2, head = 5, no ack. Assert recover_i → tail = 7, insts = 2, and the drain of entries 5 and 6 completes normally.
- Same cycle: dispatch 2, commit 1, ack 1, from insts = 5 and commitPend = 1 → insts = 6, commitPend = 1, FSM remains in REQ.
- Assert reset low while cacheWrReq_o = 1 → all outputs return to reset values immediately, without waiting for a clock edge.

Source files
------------

// File: rtl/stq_ctrl.sv
// stq_ctrl -- store-queue occupancy controller.
//
// Owns the store queue's head/tail/occupancy registers. Each cycle it allocates
// entries for accepted dispatch bundles, tracks how many committed stores still
// have to be written to the data cache, drains them one per acknowledged
// request, and on recovery rolls the tail back so that only committed stores
// remain in the queue.
//
// Ports:
//   clk, reset          core clock; asynchronous active-low reset
//   dispatchValid_i     dispatch bundle present; cntStNew_i = stores in it (0..4)
//   commitCnt_i         oldest uncommitted stores committed this cycle (0..4)
//   recover_i           flush every uncommitted store
//   cacheWrAck_i        data cache accepted the current store write
//   stqHead_o/stqTail_o oldest entry / next free entry
//   stqInsts_o          occupied entries, 0..SIZE_LSQ
//   stqFull_o           fewer than four free entries
//   dispatchAccept_o    combinational dispatch accept
//   cacheWrReq_o        store write request; cacheWrIdx_o = entry being written
module stq_ctrl #(
    parameter int SIZE_LSQ     = 32,
    parameter int SIZE_LSQ_LOG = 5
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    dispatchValid_i,
    input  logic [2:0]              cntStNew_i,
    input  logic [2:0]              commitCnt_i,
    input  logic                    recover_i,
    input  logic                    cacheWrAck_i,
    output logic [SIZE_LSQ_LOG-1:0] stqHead_o,
    output logic [SIZE_LSQ_LOG-1:0] stqTail_o,
    output logic [SIZE_LSQ_LOG:0]   stqInsts_o,
    output logic                    stqFull_o,
    output logic                    dispatchAccept_o,
    output logic                    cacheWrReq_o,
    output logic [SIZE_LSQ_LOG-1:0] cacheWrIdx_o
);
    localparam int CW = SIZE_LSQ_LOG + 1;
    localparam logic [CW-1:0] SIZE_V = CW'(SIZE_LSQ);

    typedef enum logic {S_IDLE = 1'b0, S_REQ = 1'b1} state_e;

    logic [SIZE_LSQ_LOG-1:0] head_q, head_d, tail_q, tail_d;
    logic [CW-1:0]           insts_q, insts_d, pend_q, pend_d;
    state_e                  state_q, state_d;

    logic [CW-1:0] free_cnt, alloc, ack_w, uncommitted, commit_req, commit_eff;
    logic          full, accept, ack;

    // ---------------- datapath ----------------
    always_comb begin
        free_cnt    = SIZE_V - insts_q;
        full        = free_cnt < CW'(4);
        accept      = dispatchValid_i && !full && !recover_i;
        alloc       = accept ? CW'(cntStNew_i) : '0;
        ack         = (state_q == S_REQ) && cacheWrAck_i;
        ack_w       = CW'(ack);
        // Commits can only target entries that are allocated and not yet committed.
        uncommitted = insts_q - pend_q;
        commit_req  = CW'(commitCnt_i);
        commit_eff  = (commit_req > uncommitted) ? uncommitted : commit_req;

        pend_d = pend_q + commit_eff - ack_w;
        head_d = head_q + SIZE_LSQ_LOG'(ack);

        if (recover_i) begin
            // Keep only committed-but-undrained stores, contiguous from the new head.
            insts_d = pend_d;
            tail_d  = head_d + pend_d[SIZE_LSQ_LOG-1:0];
        end else begin
            insts_d = insts_q + alloc - ack_w;
            tail_d  = tail_q + alloc[SIZE_LSQ_LOG-1:0];
        end
    end

    // ---------------- drain FSM: next state ----------------
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            S_IDLE: if (pend_d != '0) state_d = S_REQ;
            S_REQ:  if (ack && pend_d == '0) state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // ---------------- drain FSM: outputs ----------------
    always_comb begin
        cacheWrReq_o = (state_q == S_REQ);
        cacheWrIdx_o = head_q;
    end

    // ---------------- state registers ----------------
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            head_q  <= '0;
            tail_q  <= '0;
            insts_q <= '0;
            pend_q  <= '0;
            state_q <= S_IDLE;
        end else begin
            head_q  <= head_d;
            tail_q  <= tail_d;
            insts_q <= insts_d;
            pend_q  <= pend_d;
            state_q <= state_d;
        end
    end

    assign stqHead_o        = head_q;
    assign stqTail_o        = tail_q;
    assign stqInsts_o       = insts_q;
    assign stqFull_o        = full;
    assign dispatchAccept_o = accept;

endmodule
